router_ctrl_fsm: RTL and testbench

Control state machine for the 1x3 router register datapath. It decodes the packet header address and sequences the register through header latch, payload load, FIFO-full stall, parity load and parity check. It drives detect_add/lfd_state/ld_state/laf_state/full_state/rst_int_reg into the register and busy/write_enb_reg to the source and synchroniser. It sits between the packet source, the FIFO synchroniser and the register.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_wdog_cnt.sv | 30 +++
 rtl/router_ctrl_fsm.sv | 150 +++++++++++++++
 tb/tb_router_ctrl_fsm.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state encoding and constants for the router control FSM
package router_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  // Both stall states share the watchdog and the busy handshake
  function automatic logic is_stall(input state_t s);
    return (s == FFS) || (s == WTE);
  endfunction

endpackage

// File: rtl/router_wdog_cnt.sv
// rtl/router_wdog_cnt.sv - stall-duration counter with terminal-count abort for the router FSM
module router_wdog_cnt #(
  parameter int WDOG_CYCLES = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic stalled,
  input  logic staying,
  output logic trip
);

  localparam logic [7:0] TERMINAL = 8'(WDOG_CYCLES - 1);

  logic [7:0] count;

  // Counts cycles spent in one stall state; any exit or entry restarts from zero
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (stalled && staying) begin
      count <= count + 8'd1;
    end else begin
      count <= 8'd0;
    end
  end

  assign trip = stalled && (count == TERMINAL);

endmodule

// File: rtl/router_ctrl_fsm.sv
// rtl/router_ctrl_fsm.sv - 1x3 router register control FSM; stall watchdog built when ROUTER_FSM_WDOG_EN is defined
module router_ctrl_fsm #(
  parameter int NUM_PORTS   = router_pkg::NUM_PORTS,
  parameter int WDOG_CYCLES = 30
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [1:0]           data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 wdog_err
);

  import router_pkg::*;

  if (WDOG_CYCLES < 2 || WDOG_CYCLES > 255) begin : g_bad_wdog
    $error("router_ctrl_fsm: WDOG_CYCLES must be within 2..255");
  end

  state_t     state;
  state_t     next_state;
  logic [1:0] addr_reg;
  logic       capture;
  logic       sr_hit;
  logic       wdog_trip;

  // A soft reset only matters for the port the current packet is bound to
  assign sr_hit = (state != DA) && soft_reset[addr_reg];

  // Next-state decode: soft reset, then watchdog abort, then the packet flow
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    if (sr_hit || wdog_trip) begin
      next_state = DA;
    end else begin
      case (state)
        DA: begin
          if (pkt_valid && (data_in != ADDR_INVALID)) begin
            capture    = 1'b1;
            next_state = fifo_empty[data_in] ? LFD : WTE;
          end
        end
        LFD: next_state = LD;
        LD: begin
          if (fifo_full) begin
            next_state = FFS;
          end else if (!pkt_valid) begin
            next_state = LP;
          end
        end
        FFS: begin
          if (!fifo_full) begin
            next_state = LAF;
          end
        end
        LAF: begin
          if (parity_done) begin
            next_state = DA;
          end else if (low_packet_valid) begin
            next_state = LP;
          end else begin
            next_state = LD;
          end
        end
        LP:  next_state = CPE;
        CPE: next_state = fifo_full ? FFS : DA;
        WTE: begin
          if (fifo_empty[addr_reg]) begin
            next_state = LFD;
          end
        end
        default: next_state = DA;
      endcase
    end
  end

  // State, bound address and Moore outputs registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= DA;
      addr_reg      <= 2'd0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        addr_reg <= data_in;
      end
      detect_add    <= (next_state == DA);
      lfd_state     <= (next_state == LFD);
      ld_state      <= (next_state == LD);
      laf_state     <= (next_state == LAF);
      full_state    <= (next_state == FFS);
      rst_int_reg   <= (next_state == CPE);
      write_enb_reg <= (next_state == LD) || (next_state == LP) || (next_state == LAF);
      busy          <= (next_state != DA) && (next_state != LD);
    end
  end

`ifdef ROUTER_FSM_WDOG_EN
  logic stalled;
  logic staying;

  assign stalled = is_stall(state);
  assign staying = (next_state == state);

  router_wdog_cnt #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (sr_hit),
    .stalled (stalled),
    .staying (staying),
    .trip    (wdog_trip)
  );

  // Flags the first DA cycle that follows a watchdog abort
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_trip && !sr_hit;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// tb/tb_router_ctrl_fsm.sv - self-checking bench for router_ctrl_fsm against a phase-level packet model
module tb_router_ctrl_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_packet_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy, wdog_err;

  router_ctrl_fsm #(
    .NUM_PORTS   (3),
    .WDOG_CYCLES (30)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .soft_reset       (soft_reset),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .write_enb_reg    (write_enb_reg),
    .busy             (busy),
    .wdog_err         (wdog_err)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total    = 0;

  string      m_ph   = "DA";
  logic [1:0] m_addr = 2'd0;

  int cnt_lfd, cnt_ld, cnt_laf, cnt_full, cnt_rst, cnt_wen, cnt_wte;

  // Output vector {detect,lfd,ld,laf,full,rst_int,write_enb,busy} each phase must show
  function automatic logic [7:0] exp_vec(input string ph);
    if (ph == "DA")  return 8'b1000_0000;
    if (ph == "LFD") return 8'b0100_0001;
    if (ph == "LD")  return 8'b0010_0010;
    if (ph == "FFS") return 8'b0000_1001;
    if (ph == "LAF") return 8'b0001_0011;
    if (ph == "LP")  return 8'b0000_0011;
    if (ph == "CPE") return 8'b0000_0101;
    return 8'b0000_0001;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_ph   = "DA";
      m_addr = 2'd0;
    end else if (m_ph != "DA" && soft_reset[m_addr]) begin
      m_ph = "DA";
    end else if (m_ph == "DA") begin
      if (pkt_valid && data_in != 2'd3) begin
        m_addr = data_in;
        if (fifo_empty[data_in]) m_ph = "LFD";
        else                     m_ph = "WTE";
      end
    end else if (m_ph == "LFD") begin
      m_ph = "LD";
    end else if (m_ph == "LD") begin
      if (fifo_full)       m_ph = "FFS";
      else if (!pkt_valid) m_ph = "LP";
    end else if (m_ph == "FFS") begin
      if (!fifo_full) m_ph = "LAF";
    end else if (m_ph == "LAF") begin
      if (parity_done)           m_ph = "DA";
      else if (low_packet_valid) m_ph = "LP";
      else                       m_ph = "LD";
    end else if (m_ph == "LP") begin
      m_ph = "CPE";
    end else if (m_ph == "CPE") begin
      if (fifo_full) m_ph = "FFS";
      else           m_ph = "DA";
    end else begin
      if (fifo_empty[m_addr]) m_ph = "LFD";
    end
  endtask

  task automatic compare();
    logic [7:0] act;
    logic [7:0] exp;
    act = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy};
    exp = exp_vec(m_ph);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL outputs phase=%s actual=%b required=%b at %0t", m_ph, act, exp, $time);
    total++;
    if (wdog_err === 1'b0) pass_cnt++;
    else $display("FAIL wdog_err actual=%b required=0 at %0t", wdog_err, $time);
    if (lfd_state)     cnt_lfd++;
    if (ld_state)      cnt_ld++;
    if (laf_state)     cnt_laf++;
    if (full_state)    cnt_full++;
    if (rst_int_reg)   cnt_rst++;
    if (write_enb_reg) cnt_wen++;
    if (act == 8'b0000_0001) cnt_wte++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare();
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic clear_counts();
    cnt_lfd = 0; cnt_ld = 0; cnt_laf = 0; cnt_full = 0;
    cnt_rst = 0; cnt_wen = 0; cnt_wte = 0;
  endtask

  task automatic drive(input logic pv, input logic [1:0] din, input logic ff,
                       input logic [2:0] fe, input logic [2:0] sr,
                       input logic pd, input logic lpv);
    pkt_valid        = pv;
    data_in          = din;
    fifo_full        = ff;
    fifo_empty       = fe;
    soft_reset       = sr;
    parity_done      = pd;
    low_packet_valid = lpv;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 3'b111, 3'b000, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 3'b111, 3'b000, 0, 0);
    clear_counts();

    // Reset state
    do_reset();
    check("reset_detect_add", int'(detect_add), 1);
    check("reset_busy", int'(busy), 0);

    // Clean packet to port 2, five payload cycles
    clear_counts();
    drive(1, 2, 0, 3'b111, 3'b000, 0, 0);
    tick();
    repeat (5) tick();
    drive(0, 2, 0, 3'b111, 3'b000, 0, 0);
    repeat (3) tick();
    check("pkt_lfd_cycles", cnt_lfd, 1);
    check("pkt_ld_cycles", cnt_ld, 5);
    check("pkt_rst_int_cycles", cnt_rst, 1);
    check("pkt_write_cycles", cnt_wen, 6);
    check("pkt_end_detect_add", int'(detect_add), 1);
    check("pkt_end_busy", int'(busy), 0);

    // Port 2 not empty: wait four cycles then load first data
    do_reset();
    clear_counts();
    drive(1, 2, 0, 3'b011, 3'b000, 0, 0);
    repeat (4) tick();
    check("wte_cycles", cnt_wte, 4);
    drive(1, 2, 0, 3'b111, 3'b000, 0, 0);
    tick();
    check("wte_to_lfd", int'(lfd_state), 1);

    // Three-cycle FIFO-full stall mid-payload, resume to LD
    do_reset();
    drive(1, 1, 0, 3'b111, 3'b000, 0, 0);
    repeat (3) tick();
    clear_counts();
    drive(1, 1, 1, 3'b111, 3'b000, 0, 0);
    repeat (3) tick();
    check("ffs_cycles", cnt_full, 3);
    check("ffs_no_write", cnt_wen, 0);
    drive(1, 1, 0, 3'b111, 3'b000, 0, 0);
    tick();
    check("laf_after_full", int'(laf_state), 1);
    tick();
    check("laf_back_to_ld", int'(ld_state), 1);

    // fifo_full beats pkt_valid falling; LAF with low_packet_valid goes to parity
    drive(0, 1, 1, 3'b111, 3'b000, 0, 1);
    tick();
    check("full_beats_parity", int'(full_state), 1);
    drive(0, 1, 0, 3'b111, 3'b000, 0, 1);
    tick();
    check("laf_entry", int'(laf_state), 1);
    tick();
    check("lp_after_laf", int'(write_enb_reg & busy & ~ld_state), 1);
    tick();
    check("cpe_after_lp", int'(rst_int_reg), 1);
    tick();
    check("da_after_cpe", int'(detect_add), 1);

    // Soft reset on the bound port aborts; on another port it does nothing
    do_reset();
    drive(1, 2, 0, 3'b111, 3'b000, 0, 0);
    repeat (2) tick();
    drive(1, 2, 0, 3'b111, 3'b001, 0, 0);
    tick();
    check("soft_reset_other_port", int'(ld_state), 1);
    drive(1, 2, 0, 3'b111, 3'b100, 0, 0);
    tick();
    check("soft_reset_bound_port", int'(detect_add), 1);
    drive(1, 3, 0, 3'b111, 3'b000, 0, 0);
    repeat (3) tick();
    check("invalid_addr_dropped", int'(detect_add), 1);

    // Long stall: no watchdog in this build, FFS holds
    do_reset();
    drive(1, 0, 0, 3'b111, 3'b000, 0, 0);
    repeat (2) tick();
    clear_counts();
    drive(1, 0, 1, 3'b111, 3'b000, 0, 0);
    repeat (60) tick();
    check("long_stall_ffs_cycles", cnt_full, 60);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset            = ($urandom_range(0, 199) == 0);
      pkt_valid        = ($urandom_range(0, 9) < 8);
      data_in          = 2'($urandom_range(0, 3));
      fifo_full        = ($urandom_range(0, 99) < 15);
      for (int b = 0; b < 3; b++) begin
        fifo_empty[b] = ($urandom_range(0, 9) < 7);
        soft_reset[b] = ($urandom_range(0, 99) < 3);
      end
      parity_done      = ($urandom_range(0, 9) < 3);
      low_packet_valid = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
